// File: rtl/data_mem_responder.sv
// Word-organised data memory answering the MEM stage load/store port.
// Ports: clk, rst, req_* (valid/ready request), resp_* (valid/ready response).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTES = 32'(DEPTH_WORDS * 4);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rv_q, rv_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic          acc_err;
  logic [AW-1:0] idx;
  logic          mem_we;

  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q >= BYTES);
  assign idx     = addr_q[AW+1:2];

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = rv_q;
  assign resp_rdata = rd_q;
  assign resp_err   = err_q;

  // The counter is loaded with LATENCY at acceptance and the access
  // is performed on the edge where it reads 1, so the response rises
  // exactly LATENCY edges after the accepting edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          be_d    = req_be;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          rv_d    = 1'b1;
          err_d   = acc_err;
          rd_d    = 32'h0;
          if (!acc_err && !we_q) rd_d = mem[idx];
          mem_we  = we_q && !acc_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
          rd_d    = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rv_q    <= 1'b0;
      rd_q    <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
